// File: rtl/note_sequencer.sv
// Melody engine: steps a writable (note,dur) song memory on a tempo tick and drives a one-hot note bus.
// Outputs decode registered state; start enters LOAD next cycle; stop forces IDLE with no done pulse.
module note_sequencer #(
  parameter int TICK_DIV  = 2500000,
  parameter int SONG_LEN  = 16,
  parameter int ADDR_W    = 4,
  parameter int GAP_TICKS = 1
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              start,
  input  logic              stop,
  input  logic              loop,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [9:0]        wr_data,
  output logic [31:0]       note_out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] step_idx
);
  localparam int CNT_W = $clog2(TICK_DIV);
  localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = CNT_W'(TICK_DIV - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SONG_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_INIT  = GAP_W'(GAP_TICKS);
  localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP, S_DONE} state_t;

  state_t            state;
  logic [9:0]        mem [SONG_LEN];
  logic [ADDR_W-1:0] addr;
  logic [4:0]        note_r;
  logic [4:0]        remaining;
  logic [CNT_W-1:0]  tick_cnt;
  logic [GAP_W-1:0]  gap_left;
  logic [4:0]        rd_dur;
  logic [4:0]        rd_note;
  logic              tick;
  logic              last_addr;

  // No reset on the song memory; a same-cycle LOAD sees the pre-write contents.
  always_ff @(posedge CLOCK_50) begin
    if (wr_en)
      mem[wr_addr] <= wr_data;
  end

  assign {rd_dur, rd_note} = mem[addr];
  assign tick      = (tick_cnt == CNT_MAX);
  assign last_addr = (addr == LAST_ADDR);

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      addr      <= '0;
      note_r    <= '0;
      remaining <= '0;
      tick_cnt  <= '0;
      gap_left  <= '0;
    end else if (stop) begin
      state    <= S_IDLE;
      tick_cnt <= '0;
    end else begin
      tick_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr  <= '0;
            state <= S_LOAD;
          end
        end
        S_LOAD: begin
          note_r    <= rd_note;
          remaining <= rd_dur;
          if (rd_dur == 5'd0) begin
            // Looping only from a non-zero address keeps an empty song from spinning.
            if ((addr != '0) && loop) begin
              addr  <= '0;
              state <= S_LOAD;
            end else begin
              state <= S_DONE;
            end
          end else begin
            state <= S_PLAY;
          end
        end
        S_PLAY: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (tick) begin
            remaining <= remaining - 1'b1;
            if (remaining == 5'd1) begin
              if (GAP_TICKS == 0) begin
                addr  <= addr + 1'b1;
                state <= (last_addr && !loop) ? S_DONE : S_LOAD;
              end else begin
                gap_left <= GAP_INIT;
                state    <= S_GAP;
              end
            end
          end
        end
        S_GAP: begin
          tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
          if (tick) begin
            gap_left <= gap_left - 1'b1;
            if (gap_left == GAP_ONE) begin
              addr  <= addr + 1'b1;
              state <= (last_addr && !loop) ? S_DONE : S_LOAD;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    note_out = '0;
    if ((state == S_PLAY) && (note_r <= 5'd29))
      note_out = 32'd1 << note_r;
  end

  assign busy     = (state == S_LOAD) || (state == S_PLAY) || (state == S_GAP);
  assign done     = (state == S_DONE);
  assign step_idx = addr;

endmodule

// File: tb/tb_note_sequencer.sv
// Bench for note_sequencer: a timeline model expands each song entry into per-cycle expectations.
module tb_note_sequencer;
  localparam int TD = 4;
  localparam int GT = 1;
  localparam int SL = 16;
  localparam int AW = 4;

  logic          CLOCK_50 = 1'b0;
  logic          resetn   = 1'b0;
  logic          start    = 1'b0;
  logic          stop     = 1'b0;
  logic          loop     = 1'b0;
  logic          wr_en    = 1'b0;
  logic [AW-1:0] wr_addr  = '0;
  logic [9:0]    wr_data  = '0;
  logic [31:0]   note_out;
  logic          busy;
  logic          done;
  logic [AW-1:0] step_idx;

  int n_cmp = 0;
  int n_bad = 0;

  note_sequencer #(.TICK_DIV(TD), .SONG_LEN(SL), .ADDR_W(AW), .GAP_TICKS(GT)) dut (
    .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start), .stop(stop), .loop(loop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .note_out(note_out), .busy(busy), .done(done), .step_idx(step_idx)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct packed {
    logic [31:0]   note;
    logic          busy;
    logic          done;
    logic [AW-1:0] step;
  } exp_t;

  typedef enum {P_LOAD, P_ENTRY, P_DONE} pend_t;

  exp_t       q[$];
  exp_t       cur;
  logic [9:0] m_mem [SL];
  bit         running = 1'b0;
  int         m_addr  = 0;
  pend_t      pend    = P_DONE;
  int c_h1, c_top, c_h20, c_h80, c_busy, c_done, done_step;

  function automatic logic [31:0] tone(int n);
    return (n <= 29) ? (32'd1 << n) : 32'd0;
  endfunction

  task automatic push(logic [31:0] nt, bit b, bit d, int s);
    exp_t e;
    e.note = nt;
    e.busy = b;
    e.done = d;
    e.step = s[AW-1:0];
    q.push_back(e);
  endtask

  // Decide what follows once the expanded timeline of the previous step has been consumed.
  task automatic resolve();
    int d;
    int n;
    case (pend)
      P_LOAD: begin
        d = int'(m_mem[m_addr][9:5]);
        n = int'(m_mem[m_addr][4:0]);
        if (d == 0) begin
          if (m_addr != 0 && loop) begin
            m_addr = 0;
            push(32'd0, 1'b1, 1'b0, 0);
            pend = P_LOAD;
          end else begin
            push(32'd0, 1'b0, 1'b1, m_addr);
            pend = P_DONE;
          end
        end else begin
          repeat (d * TD) push(tone(n), 1'b1, 1'b0, m_addr);
          repeat (GT * TD) push(32'd0, 1'b1, 1'b0, m_addr);
          pend = P_ENTRY;
        end
      end
      P_ENTRY: begin
        if (m_addr == SL - 1) begin
          m_addr = 0;
          if (loop) begin
            push(32'd0, 1'b1, 1'b0, 0);
            pend = P_LOAD;
          end else begin
            push(32'd0, 1'b0, 1'b1, 0);
            pend = P_DONE;
          end
        end else begin
          m_addr = m_addr + 1;
          push(32'd0, 1'b1, 1'b0, m_addr);
          pend = P_LOAD;
        end
      end
      default: running = 1'b0;
    endcase
  endtask

  task automatic model_step();
    if (!resetn || stop) begin
      q.delete();
      running = 1'b0;
    end else if (!running) begin
      if (start) begin
        running = 1'b1;
        m_addr  = 0;
        push(32'd0, 1'b1, 1'b0, 0);
        pend = P_LOAD;
      end
    end else if (q.size() == 0) begin
      resolve();
    end
    if (running && q.size() > 0) cur = q.pop_front();
    else cur = '0;
    if (wr_en) m_mem[wr_addr] = wr_data;
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic clear_tally();
    c_h1 = 0; c_top = 0; c_h20 = 0; c_h80 = 0; c_busy = 0; c_done = 0; done_step = -1;
  endtask

  task automatic cycle();
    @(posedge CLOCK_50);
    model_step();
    #1;
    chk("note_out", note_out, cur.note);
    chk("busy", {31'd0, busy}, {31'd0, cur.busy});
    chk("done", {31'd0, done}, {31'd0, cur.done});
    if (cur.busy || cur.done) chk("step_idx", {28'd0, step_idx}, {28'd0, cur.step});
    if (note_out == 32'h1) c_h1++;
    if (note_out == 32'h2000_0000) c_top++;
    if (note_out == 32'h20) c_h20++;
    if (note_out == 32'h80) c_h80++;
    if (busy) c_busy++;
    if (done) begin
      c_done++;
      done_step = int'(step_idx);
    end
  endtask

  task automatic run(int n);
    repeat (n) cycle();
  endtask

  task automatic wr(int a, int d, int n);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = {d[4:0], n[4:0]};
    cycle();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
  endtask

  task automatic basic_song();
    wr(0, 2, 0);
    wr(1, 1, 31);
    wr(2, 1, 29);
    wr(3, 0, 0);
  endtask

  initial begin
    clear_tally();
    run(2);
    chk("rst_note", note_out, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_step", {28'd0, step_idx}, 32'd0);
    resetn = 1'b1;
    for (int a = 0; a < SL; a++) wr(a, 0, 0);

    // Basic song
    basic_song();
    run(2);
    clear_tally();
    pulse_start();
    chk("start_busy", {31'd0, busy}, 32'd1);
    chk("start_step", {28'd0, step_idx}, 32'd0);
    run(40);
    chk("basic_h1_cycles", c_h1, 8);
    chk("basic_n29_cycles", c_top, 4);
    chk("basic_busy_cycles", c_busy, 32);
    chk("basic_done_pulses", c_done, 1);

    // Loop: 32-cycle period, third pass of entry 0 lands within the window
    loop = 1'b1;
    clear_tally();
    pulse_start();
    run(79);
    stop = 1'b1;
    cycle();
    stop = 1'b0;
    loop = 1'b0;
    chk("loop_h1_cycles", c_h1, 24);
    chk("loop_done_pulses", c_done, 0);
    chk("loop_stop_busy", {31'd0, busy}, 32'd0);
    run(2);

    // Empty song with loop
    wr(0, 0, 0);
    loop = 1'b1;
    clear_tally();
    pulse_start();
    run(5);
    loop = 1'b0;
    chk("empty_busy_cycles", c_busy, 1);
    chk("empty_done_pulses", c_done, 1);

    // Wrap through all entries
    for (int a = 0; a < SL; a++) wr(a, 1, 5);
    clear_tally();
    pulse_start();
    run(150);
    chk("wrap_h20_cycles", c_h20, 64);
    chk("wrap_done_pulses", c_done, 1);
    chk("wrap_done_step", done_step, 0);

    // Stop together with start mid-PLAY
    wr(0, 4, 3);
    wr(1, 0, 0);
    pulse_start();
    run(5);
    stop  = 1'b1;
    start = 1'b1;
    cycle();
    stop  = 1'b0;
    start = 1'b0;
    chk("stop_note", note_out, 32'd0);
    chk("stop_busy", {31'd0, busy}, 32'd0);
    chk("stop_done", {31'd0, done}, 32'd0);
    run(3);
    pulse_start();
    chk("restart_step", {28'd0, step_idx}, 32'd0);
    cycle();
    chk("restart_note", note_out, 32'h8);
    run(25);

    // Live write of entry 1 while entry 0 plays
    basic_song();
    clear_tally();
    pulse_start();
    run(2);
    wr(1, 2, 7);
    run(40);
    chk("live_h80_cycles", c_h80, 8);

    // Asynchronous reset in the gap of entry 1, then in PLAY of entry 0
    pulse_start();
    run(23);
    chk("pre_rst_step", {28'd0, step_idx}, 32'd1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_step", {28'd0, step_idx}, 32'd0);
    run(2);
    resetn = 1'b1;
    pulse_start();
    run(3);
    chk("pre_rst_note", note_out, 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("arst_note", note_out, 32'd0);
    run(1);
    resetn = 1'b1;
    run(2);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      wr_en   = ($urandom_range(0, 9) == 0);
      wr_addr = AW'($urandom_range(0, SL - 1));
      wr_data = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 31))};
      start   = ($urandom_range(0, 7) == 0);
      stop    = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 99) == 0) loop = ~loop;
      resetn  = ($urandom_range(0, 999) != 0);
      cycle();
    end
    wr_en  = 1'b0;
    start  = 1'b0;
    stop   = 1'b0;
    resetn = 1'b1;
    run(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
